// File: rtl/mole_spawner_pkg.sv
// Shared constants and helpers for the whack-a-mole spawner: default board size,
// Galois LFSR tap masks per width, and small constant-friendly math helpers.
package mole_pkg;

  localparam int DEFAULT_NUM_HOLES = 5;
  localparam int MAX_HOLES         = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_HOLES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_HOLES; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

  // Right-shift Galois masks giving maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h0006;
      4:       return 32'h000C;
      5:       return 32'h0014;
      6:       return 32'h0030;
      7:       return 32'h0060;
      8:       return 32'h00B8;
      9:       return 32'h0110;
      10:      return 32'h0240;
      11:      return 32'h0500;
      16:      return 32'hB400;
      default: return 32'h00B8;
    endcase
  endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Game-side bundle of the mole spawner: control strobes in, mole mask and
// per-cycle score events out.
interface mole_spawner_if import mole_pkg::*; #(
  parameter int NUM_HOLES = DEFAULT_NUM_HOLES
);

  localparam int CNT_W = clog2(NUM_HOLES + 1);

  logic                 enable;
  logic                 pulse;
  logic [NUM_HOLES-1:0] whack;
  logic [NUM_HOLES-1:0] mole_position;
  logic [NUM_HOLES-1:0] hit_mask;
  logic [NUM_HOLES-1:0] miss_mask;
  logic                 wrong;
  logic [CNT_W-1:0]     active_count;

  modport master (
    output enable, pulse, whack,
    input  mole_position, hit_mask, miss_mask, wrong, active_count
  );

  modport slave (
    input  enable, pulse, whack,
    output mole_position, hit_mask, miss_mask, wrong, active_count
  );

endinterface

// File: rtl/mole_lfsr.sv
// Galois right-shift LFSR used as the spawner's random hole source.
// A zero seed would lock the register, so it is replaced by 1.
module mole_lfsr #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = W'(32'hB8),
  parameter logic [W-1:0] SEED = W'(32'h01)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= SEED_EFF;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Multi-mole generator: ages moles on each game pulse, scores hits/misses/wrong
// whacks, and spawns at most one new mole per pulse at an LFSR-chosen free hole.
module mole_spawner import mole_pkg::*; #(
  parameter int                NUM_HOLES  = DEFAULT_NUM_HOLES,
  parameter int                MAX_ACTIVE = 2,
  parameter int                LIFETIME   = 3,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(lfsr_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(1)
) (
  input logic           clock,
  input logic           reset,
  mole_spawner_if.slave bus
);

  localparam int LT_W  = clog2(LIFETIME + 1);
  localparam int IDX_W = clog2(NUM_HOLES);
  localparam int CNT_W = clog2(NUM_HOLES + 1);

  typedef logic [NUM_HOLES-1:0] mask_t;
  typedef logic [LT_W-1:0]      life_t;

  logic [LFSR_W-1:0] lfsr_value;
  logic [IDX_W-1:0]  idx;

  mask_t            position_q, hit_q, miss_q;
  logic             wrong_q;
  logic [CNT_W-1:0] count_q;
  life_t            life_q [NUM_HOLES];

  mask_t hit_d, expired_d, survivors, spawn_d, position_d;
  logic  wrong_d, room, found;
  life_t life_d [NUM_HOLES];

  mole_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (bus.enable),
    .value   (lfsr_value)
  );

  assign idx = IDX_W'(lfsr_value % LFSR_W'(NUM_HOLES));

  always_comb begin
    hit_d     = bus.whack & position_q;
    wrong_d   = |(bus.whack & ~position_q);
    expired_d = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      life_d[i] = life_q[i];
      if (hit_d[i]) begin
        life_d[i] = '0;
      end else if (bus.pulse && position_q[i]) begin
        life_d[i] = life_q[i] - life_t'(1);
        if (life_q[i] == life_t'(1)) expired_d[i] = 1'b1;
      end
    end

    survivors = position_q & ~(hit_d | expired_d);
    room      = bus.pulse && (popcount(MAX_HOLES'(survivors)) < MAX_ACTIVE);

    // Hole i sits at search distance k from idx when idx == (i - k) mod NUM_HOLES;
    // scanning k outermost yields the first free hole in rotating order.
    spawn_d = '0;
    found   = 1'b0;
    if (room) begin
      for (int k = 0; k < NUM_HOLES; k++) begin
        for (int i = 0; i < NUM_HOLES; i++) begin
          if (!found && !position_q[i] &&
              int'(idx) == (i - k + NUM_HOLES) % NUM_HOLES) begin
            spawn_d[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < NUM_HOLES; i++) begin
      if (spawn_d[i]) life_d[i] = life_t'(LIFETIME);
    end
    position_d = survivors | spawn_d;
  end

  always_ff @(posedge clock) begin
    if (!reset || !bus.enable) begin
      position_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      wrong_q    <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= '0;
    end else begin
      position_q <= position_d;
      hit_q      <= hit_d;
      miss_q     <= expired_d;
      wrong_q    <= wrong_d;
      count_q    <= CNT_W'(popcount(MAX_HOLES'(position_d)));
      for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= life_d[i];
    end
  end

  assign bus.mole_position = position_q;
  assign bus.hit_mask      = hit_q;
  assign bus.miss_mask     = miss_q;
  assign bus.wrong         = wrong_q;
  assign bus.active_count  = count_q;

endmodule
